hazard_ctrl: RTL and testbench

Central stall/flush/forwarding controller for the 5-stage MIPS pipeline. It consumes each stage's hazard-intent bits (Want/Need per operand), destination registers and write-enables. It drives the per-stage Stall/Flush inputs of the IF/ID, ID/EX and EX/MEM registers and the ID/EX operand forwarding selects. It also sequences the multi-cycle MUL/DIV unit and the data-memory wait handshake, and holds their busy state.

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/mdu_seq.sv | 66 ++++++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  // Bit positions inside the ID-stage DP_Hazards vector
  localparam int unsigned HZ_WANT_RS_ID = 7;
  localparam int unsigned HZ_NEED_RS_ID = 6;
  localparam int unsigned HZ_WANT_RT_ID = 5;
  localparam int unsigned HZ_NEED_RT_ID = 4;
  localparam int unsigned HZ_WANT_RS_EX = 3;
  localparam int unsigned HZ_NEED_RS_EX = 2;
  localparam int unsigned HZ_WANT_RT_EX = 1;
  localparam int unsigned HZ_NEED_RT_EX = 0;

  typedef logic mdu_state_t;
  localparam mdu_state_t MDU_IDLE = 1'b0;
  localparam mdu_state_t MDU_BUSY = 1'b1;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t MEM_IDLE  = 2'd0;
  localparam mem_state_t MEM_WAIT  = 2'd1;
  localparam mem_state_t MEM_DRAIN = 2'd2;

  localparam int unsigned MUL_CYCLES_DEF  = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // A producer matches only when it writes a real (non-$0) register
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return we && (dst != 5'd0) && (src == dst);
  endfunction

  // MEM wins over WB; a load still in MEM has no data to forward yet
  function automatic fwd_sel_t fwd_pick(input logic want, input logic m_hit,
                                        input logic m_load, input logic wb_hit);
    fwd_sel_t sel;
    sel = FWD_NONE;
    if (want && m_hit && !m_load) sel = FWD_MEM;
    else if (want && wb_hit)      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle MUL/DIV occupancy sequencer: tracks busy time and stalls EX users of HI/LO.
module mdu_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic div_i,
  input  logic hold_i,
  input  logic use_i,
  output logic busy_o,
  output logic stall_c
);

  localparam int unsigned MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   load_val;
  logic               launch;

  assign load_val = div_i ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
  assign launch   = start_i && !hold_i;
  assign busy_o   = (state_q == MDU_BUSY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result is ready in the final busy cycle, so only earlier cycles stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (launch) begin
          state_d = MDU_BUSY;
          cnt_d   = load_val;
        end
      end
      MDU_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          stall_c = use_i;
        end else if (launch) begin
          cnt_d   = load_val;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with MDU and data-memory wait sequencing.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic [7:0] ID_DP_Hazards,
  input  logic [4:0] EX_Rs,
  input  logic [4:0] EX_Rt,
  input  logic       EX_WantRsByEX,
  input  logic       EX_NeedRsByEX,
  input  logic       EX_WantRtByEX,
  input  logic       EX_NeedRtByEX,
  input  logic [4:0] EX_RtRd,
  input  logic       EX_RegWrite,
  input  logic [4:0] M_RtRd,
  input  logic       M_RegWrite,
  input  logic       M_MemRead,
  input  logic [4:0] WB_RtRd,
  input  logic       WB_RegWrite,
  input  logic       EX_MduStart,
  input  logic       EX_MduDiv,
  input  logic       EX_ReadHiLo,
  input  logic       M_MemReq,
  input  logic       M_MemAck,
  input  logic       EXC_Flush,
  output logic       IF_Stall,
  output logic       ID_Stall,
  output logic       EX_Stall,
  output logic       M_Stall,
  output logic       ID_Flush,
  output logic       EX_Flush,
  output logic       M_Flush,
  output logic [1:0] ID_FwdRs,
  output logic [1:0] ID_FwdRt,
  output logic [1:0] EX_FwdRs,
  output logic [1:0] EX_FwdRt,
  output logic       Mdu_Busy,
  output logic       M_BusErr
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic id_rs_ex, id_rt_ex, id_rs_m, id_rt_m, id_rs_wb, id_rt_wb;
  logic ex_rs_m, ex_rt_m, ex_rs_wb, ex_rt_wb;
  logic id_hz, ex_hz, live;
  logic mem_stall, bus_err, mdu_stall_c, mdu_busy, ex_pre_mdu;
  logic unused_dp;

  mem_state_t       mem_state_q, mem_state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign unused_dp = ^{ID_DP_Hazards[HZ_WANT_RS_EX], ID_DP_Hazards[HZ_NEED_RS_EX],
                       ID_DP_Hazards[HZ_WANT_RT_EX], ID_DP_Hazards[HZ_NEED_RT_EX]};

  assign id_rs_ex = reg_hit(ID_Rs, EX_RtRd, EX_RegWrite);
  assign id_rt_ex = reg_hit(ID_Rt, EX_RtRd, EX_RegWrite);
  assign id_rs_m  = reg_hit(ID_Rs, M_RtRd,  M_RegWrite);
  assign id_rt_m  = reg_hit(ID_Rt, M_RtRd,  M_RegWrite);
  assign id_rs_wb = reg_hit(ID_Rs, WB_RtRd, WB_RegWrite);
  assign id_rt_wb = reg_hit(ID_Rt, WB_RtRd, WB_RegWrite);
  assign ex_rs_m  = reg_hit(EX_Rs, M_RtRd,  M_RegWrite);
  assign ex_rt_m  = reg_hit(EX_Rt, M_RtRd,  M_RegWrite);
  assign ex_rs_wb = reg_hit(EX_Rs, WB_RtRd, WB_RegWrite);
  assign ex_rt_wb = reg_hit(EX_Rt, WB_RtRd, WB_RegWrite);

  assign id_hz = (ID_DP_Hazards[HZ_NEED_RS_ID] && (id_rs_ex || (id_rs_m && M_MemRead))) ||
                 (ID_DP_Hazards[HZ_NEED_RT_ID] && (id_rt_ex || (id_rt_m && M_MemRead)));
  assign ex_hz = M_MemRead && ((EX_NeedRsByEX && ex_rs_m) || (EX_NeedRtByEX && ex_rt_m));

  assign ID_FwdRs = RST ? 2'b00 : fwd_pick(ID_DP_Hazards[HZ_WANT_RS_ID], id_rs_m, M_MemRead, id_rs_wb);
  assign ID_FwdRt = RST ? 2'b00 : fwd_pick(ID_DP_Hazards[HZ_WANT_RT_ID], id_rt_m, M_MemRead, id_rt_wb);
  assign EX_FwdRs = RST ? 2'b00 : fwd_pick(EX_WantRsByEX, ex_rs_m, M_MemRead, ex_rs_wb);
  assign EX_FwdRt = RST ? 2'b00 : fwd_pick(EX_WantRtByEX, ex_rt_m, M_MemRead, ex_rt_wb);

  // Flush overrides every stall; reset silences everything
  assign live       = !RST && !EXC_Flush;
  assign M_Stall    = live && mem_stall;
  assign ex_pre_mdu = M_Stall || (live && ex_hz);
  assign EX_Stall   = ex_pre_mdu || (live && mdu_stall_c);
  assign ID_Stall   = EX_Stall || (live && id_hz);
  assign IF_Stall   = ID_Stall;
  assign ID_Flush   = !RST && EXC_Flush;
  assign EX_Flush   = !RST && EXC_Flush;
  assign M_Flush    = !RST && EXC_Flush;
  assign Mdu_Busy   = !RST && mdu_busy;
  assign M_BusErr   = !RST && bus_err;

  mdu_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_seq (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (EX_MduStart),
    .div_i   (EX_MduDiv),
    .hold_i  (ex_pre_mdu),
    .use_i   (EX_MduStart || EX_ReadHiLo),
    .busy_o  (mdu_busy),
    .stall_c (mdu_stall_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_state_q <= MEM_IDLE;
      tmo_q       <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      tmo_q       <= tmo_d;
    end
  end

  // DRAIN swallows the ack of an abandoned request before accepting new ones
  always_comb begin
    mem_state_d = mem_state_q;
    tmo_d       = tmo_q;
    mem_stall   = 1'b0;
    bus_err     = 1'b0;
    case (mem_state_q)
      MEM_IDLE: begin
        if (M_MemReq && !M_MemAck) begin
          mem_stall   = 1'b1;
          tmo_d       = '0;
          mem_state_d = EXC_Flush ? MEM_DRAIN : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (M_MemAck) begin
          mem_state_d = MEM_IDLE;
        end else if (tmo_q == TMO_W'(MEM_TIMEOUT)) begin
          bus_err     = 1'b1;
          mem_state_d = MEM_DRAIN;
        end else if (EXC_Flush) begin
          mem_state_d = MEM_DRAIN;
        end else begin
          mem_stall   = 1'b1;
          tmo_d       = tmo_q + TMO_W'(1);
        end
      end
      MEM_DRAIN: begin
        mem_stall = M_MemReq;
        if (M_MemAck) mem_state_d = MEM_IDLE;
      end
      default: mem_state_d = MEM_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, M_RtRd, WB_RtRd;
  logic [7:0] ID_DP_Hazards;
  logic       EX_WantRsByEX, EX_NeedRsByEX, EX_WantRtByEX, EX_NeedRtByEX;
  logic       EX_RegWrite, M_RegWrite, M_MemRead, WB_RegWrite;
  logic       EX_MduStart, EX_MduDiv, EX_ReadHiLo, M_MemReq, M_MemAck, EXC_Flush;
  logic       IF_Stall, ID_Stall, EX_Stall, M_Stall, ID_Flush, EX_Flush, M_Flush;
  logic [1:0] ID_FwdRs, ID_FwdRt, EX_FwdRs, EX_FwdRt;
  logic       Mdu_Busy, M_BusErr;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl u_dut (
    .CLK (CLK), .RST (RST),
    .ID_Rs (ID_Rs), .ID_Rt (ID_Rt), .ID_DP_Hazards (ID_DP_Hazards),
    .EX_Rs (EX_Rs), .EX_Rt (EX_Rt),
    .EX_WantRsByEX (EX_WantRsByEX), .EX_NeedRsByEX (EX_NeedRsByEX),
    .EX_WantRtByEX (EX_WantRtByEX), .EX_NeedRtByEX (EX_NeedRtByEX),
    .EX_RtRd (EX_RtRd), .EX_RegWrite (EX_RegWrite),
    .M_RtRd (M_RtRd), .M_RegWrite (M_RegWrite), .M_MemRead (M_MemRead),
    .WB_RtRd (WB_RtRd), .WB_RegWrite (WB_RegWrite),
    .EX_MduStart (EX_MduStart), .EX_MduDiv (EX_MduDiv), .EX_ReadHiLo (EX_ReadHiLo),
    .M_MemReq (M_MemReq), .M_MemAck (M_MemAck), .EXC_Flush (EXC_Flush),
    .IF_Stall (IF_Stall), .ID_Stall (ID_Stall), .EX_Stall (EX_Stall), .M_Stall (M_Stall),
    .ID_Flush (ID_Flush), .EX_Flush (EX_Flush), .M_Flush (M_Flush),
    .ID_FwdRs (ID_FwdRs), .ID_FwdRt (ID_FwdRt), .EX_FwdRs (EX_FwdRs), .EX_FwdRt (EX_FwdRt),
    .Mdu_Busy (Mdu_Busy), .M_BusErr (M_BusErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clr;
    ID_Rs = '0; ID_Rt = '0; ID_DP_Hazards = '0; EX_Rs = '0; EX_Rt = '0;
    EX_WantRsByEX = 0; EX_NeedRsByEX = 0; EX_WantRtByEX = 0; EX_NeedRtByEX = 0;
    EX_RtRd = '0; EX_RegWrite = 0; M_RtRd = '0; M_RegWrite = 0; M_MemRead = 0;
    WB_RtRd = '0; WB_RegWrite = 0; EX_MduStart = 0; EX_MduDiv = 0; EX_ReadHiLo = 0;
    M_MemReq = 0; M_MemAck = 0; EXC_Flush = 0;
  endtask

  function automatic logic [31:0] stalls();
    return 32'({IF_Stall, ID_Stall, EX_Stall, M_Stall});
  endfunction

  function automatic logic [31:0] flushes();
    return 32'({ID_Flush, EX_Flush, M_Flush});
  endfunction

  function automatic logic [31:0] fwds();
    return 32'({ID_FwdRs, ID_FwdRt, EX_FwdRs, EX_FwdRt});
  endfunction

  initial begin
    int  b_cnt, s_cnt, st_cnt;
    logic last_stall, seen;

    // Reset: hazards, flush and memory request present but everything must read 0
    RST = 1'b1;
    clr;
    ID_Rs = 5'd3; ID_DP_Hazards = 8'hC0; M_RtRd = 5'd3; M_RegWrite = 1;
    EX_Rs = 5'd3; EX_WantRsByEX = 1; M_MemReq = 1; EXC_Flush = 1;
    tick; tick; settle;
    check("rst_stalls", stalls(), 32'h0);
    check("rst_flush", flushes(), 32'h0);
    check("rst_fwd", fwds(), 32'h0);
    check("rst_busy_err", 32'({Mdu_Busy, M_BusErr}), 32'h0);

    tick; RST = 1'b0; clr; settle;
    check("idle_stalls", stalls(), 32'h0);

    // Load-use in EX, then WB forward
    tick; clr;
    M_MemRead = 1; M_RtRd = 5'd5; M_RegWrite = 1; EX_Rs = 5'd5; EX_NeedRsByEX = 1; EX_WantRsByEX = 1;
    settle;
    check("ldu_stalls", stalls(), 32'hE);
    check("ldu_fwd", fwds(), 32'h0);
    tick; clr;
    WB_RtRd = 5'd5; WB_RegWrite = 1; EX_Rs = 5'd5; EX_NeedRsByEX = 1; EX_WantRsByEX = 1;
    settle;
    check("ldu_wb_fwd", fwds(), 32'h08);
    check("ldu_wb_stalls", stalls(), 32'h0);

    // Branch in ID depending on EX, then MEM forward
    tick; clr;
    ID_Rs = 5'd3; ID_DP_Hazards = 8'hC0; EX_RtRd = 5'd3; EX_RegWrite = 1;
    settle;
    check("br_stalls", stalls(), 32'hC);
    tick; clr;
    ID_Rs = 5'd3; ID_DP_Hazards = 8'hC0; M_RtRd = 5'd3; M_RegWrite = 1;
    settle;
    check("br_fwd", fwds(), 32'h40);
    check("br_fwd_stalls", stalls(), 32'h0);

    // rt: load in MEM stalls ID, while the WB copy is still selected
    tick; clr;
    ID_Rt = 5'd7; ID_DP_Hazards = 8'h30; M_RtRd = 5'd7; M_RegWrite = 1; M_MemRead = 1;
    WB_RtRd = 5'd7; WB_RegWrite = 1;
    settle;
    check("rt_ld_stalls", stalls(), 32'hC);
    check("rt_ld_fwd", fwds(), 32'h20);

    // Want-only never stalls
    tick; clr;
    ID_Rs = 5'd3; ID_DP_Hazards = 8'h80; EX_RtRd = 5'd3; EX_RegWrite = 1;
    settle;
    check("want_only_stalls", stalls(), 32'h0);
    check("want_only_fwd", fwds(), 32'h0);

    // $0 destinations never match
    tick; clr;
    ID_DP_Hazards = 8'hFF; EX_WantRsByEX = 1; EX_NeedRsByEX = 1; EX_WantRtByEX = 1; EX_NeedRtByEX = 1;
    EX_RegWrite = 1; M_RegWrite = 1; M_MemRead = 1; WB_RegWrite = 1;
    settle;
    check("zero_stalls", stalls(), 32'h0);
    check("zero_fwd", fwds(), 32'h0);

    // MEM has priority over WB on EX rt
    tick; clr;
    EX_Rt = 5'd9; EX_WantRtByEX = 1; M_RtRd = 5'd9; M_RegWrite = 1; WB_RtRd = 5'd9; WB_RegWrite = 1;
    settle;
    check("ex_rt_prio", fwds(), 32'h01);

    // DIV followed by MFHI held
    tick; clr; EX_MduStart = 1; EX_MduDiv = 1; settle;
    check("div_issue_busy", 32'(Mdu_Busy), 32'h0);
    check("div_issue_stall", 32'(EX_Stall), 32'h0);
    tick; EX_MduStart = 0; EX_MduDiv = 0; EX_ReadHiLo = 1; settle;
    b_cnt = 0; s_cnt = 0; last_stall = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!Mdu_Busy) break;
      b_cnt++;
      if (EX_Stall) s_cnt++;
      last_stall = EX_Stall;
      tick; settle;
    end
    check("div_busy_cycles", 32'(b_cnt), 32'd32);
    check("div_stall_cycles", 32'(s_cnt), 32'd31);
    check("div_last_stall", 32'(last_stall), 32'h0);
    check("div_done_stall", 32'(EX_Stall), 32'h0);

    // MULT occupancy
    tick; clr; EX_MduStart = 1; settle;
    tick; EX_MduStart = 0; EX_ReadHiLo = 1; settle;
    b_cnt = 0; s_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!Mdu_Busy) break;
      b_cnt++;
      if (EX_Stall) s_cnt++;
      tick; settle;
    end
    check("mul_busy_cycles", 32'(b_cnt), 32'd4);
    check("mul_stall_cycles", 32'(s_cnt), 32'd3);

    // Memory wait, ack on the fourth cycle
    tick; clr; M_MemReq = 1; settle;
    check("mw_c0", 32'(M_Stall), 32'h1);
    tick; settle;
    check("mw_c1", 32'(M_Stall), 32'h1);
    tick; settle;
    check("mw_c2", stalls(), 32'hF);
    tick; M_MemAck = 1; settle;
    check("mw_ack", 32'(M_Stall), 32'h0);
    tick; clr; M_MemReq = 1; M_MemAck = 1; settle;
    check("mw_same_ack", 32'(M_Stall), 32'h0);

    // Memory timeout
    tick; clr; M_MemReq = 1; settle;
    st_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (M_BusErr) begin
        seen = 1'b1;
        break;
      end
      if (M_Stall) st_cnt++;
      tick; settle;
    end
    check("tmo_seen", 32'(seen), 32'h1);
    check("tmo_stall_cycles", 32'(st_cnt), 32'd256);
    check("tmo_err_stall", 32'(M_Stall), 32'h0);
    tick; M_MemReq = 0; settle;
    check("tmo_pulse", 32'(M_BusErr), 32'h0);
    tick; M_MemReq = 1; settle;
    check("drain_newreq", 32'(M_Stall), 32'h1);
    tick; M_MemReq = 0; M_MemAck = 1; settle;
    check("drain_late_ack", 32'(M_Stall), 32'h0);
    tick; M_MemReq = 1; M_MemAck = 1; settle;
    check("drain_to_idle", 32'(M_Stall), 32'h0);

    // Flush during WAIT, with a load-use hazard present too
    tick; clr; M_MemReq = 1; settle;
    tick; EXC_Flush = 1;
    M_MemRead = 1; M_RtRd = 5'd5; M_RegWrite = 1; EX_Rs = 5'd5; EX_NeedRsByEX = 1;
    settle;
    check("fw_flush", flushes(), 32'h7);
    check("fw_stalls", stalls(), 32'h0);
    tick; clr; M_MemReq = 1; settle;
    check("fw_drain", 32'(M_Stall), 32'h1);
    tick; M_MemReq = 0; M_MemAck = 1; settle;
    tick; M_MemReq = 1; M_MemAck = 1; settle;
    check("fw_idle", 32'(M_Stall), 32'h0);

    // Flush during a busy MULT does not abort it
    tick; clr; EX_MduStart = 1; settle;
    tick; EX_MduStart = 0; EX_ReadHiLo = 1; settle;
    tick; EXC_Flush = 1; settle;
    check("fb_flush", flushes(), 32'h7);
    check("fb_stalls", stalls(), 32'h0);
    check("fb_busy", 32'(Mdu_Busy), 32'h1);
    tick; EXC_Flush = 0; settle;
    check("fb_c3", 32'({Mdu_Busy, EX_Stall}), 32'h3);
    tick; settle;
    check("fb_c4", 32'({Mdu_Busy, EX_Stall}), 32'h2);
    tick; settle;
    check("fb_c5", 32'({Mdu_Busy, EX_Stall}), 32'h0);

    // Reset mid-BUSY
    tick; clr; EX_MduStart = 1; EX_MduDiv = 1; settle;
    tick; clr; settle;
    check("rb_busy", 32'(Mdu_Busy), 32'h1);
    tick; RST = 1'b1; settle;
    check("rb_in_rst", 32'(Mdu_Busy), 32'h0);
    tick; RST = 1'b0; EX_ReadHiLo = 1; settle;
    check("rb_after_rst", 32'({Mdu_Busy, EX_Stall}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
